// File: rtl/hpdcache_mem_responder_if.sv
// HPDcache memory interface bundle: read and write request/response channels.
// Signal suffixes are from the responder's point of view.
interface hpdcache_mem_responder_if #(
  parameter int ADDR_W = 56,
  parameter int ID_W   = 7,
  parameter int DATA_W = 512
);
  logic              mem_req_read_valid_i;
  logic              mem_req_read_ready_o;
  logic [ADDR_W-1:0] mem_req_read_addr_i;
  logic [7:0]        mem_req_read_len_i;
  logic [ID_W-1:0]   mem_req_read_id_i;

  logic              mem_resp_read_valid_o;
  logic              mem_resp_read_ready_i;
  logic [DATA_W-1:0] mem_resp_read_data_o;
  logic [ID_W-1:0]   mem_resp_read_id_o;
  logic              mem_resp_read_error_o;
  logic              mem_resp_read_last_o;

  logic              mem_req_write_valid_i;
  logic              mem_req_write_ready_o;
  logic [ADDR_W-1:0] mem_req_write_addr_i;
  logic [7:0]        mem_req_write_len_i;
  logic [ID_W-1:0]   mem_req_write_id_i;

  logic                mem_req_write_data_valid_i;
  logic                mem_req_write_data_ready_o;
  logic [DATA_W-1:0]   mem_req_write_data_i;
  logic [DATA_W/8-1:0] mem_req_write_be_i;
  logic                mem_req_write_last_i;

  logic              mem_resp_write_valid_o;
  logic              mem_resp_write_ready_i;
  logic [ID_W-1:0]   mem_resp_write_id_o;
  logic              mem_resp_write_error_o;

  modport slave (
    input  mem_req_read_valid_i, mem_req_read_addr_i,
    input  mem_req_read_len_i, mem_req_read_id_i,
    output mem_req_read_ready_o,
    output mem_resp_read_valid_o, mem_resp_read_data_o,
    output mem_resp_read_id_o, mem_resp_read_error_o,
    output mem_resp_read_last_o,
    input  mem_resp_read_ready_i,
    input  mem_req_write_valid_i, mem_req_write_addr_i,
    input  mem_req_write_len_i, mem_req_write_id_i,
    output mem_req_write_ready_o,
    input  mem_req_write_data_valid_i, mem_req_write_data_i,
    input  mem_req_write_be_i, mem_req_write_last_i,
    output mem_req_write_data_ready_o,
    output mem_resp_write_valid_o, mem_resp_write_id_o,
    output mem_resp_write_error_o,
    input  mem_resp_write_ready_i
  );

  modport master (
    output mem_req_read_valid_i, mem_req_read_addr_i,
    output mem_req_read_len_i, mem_req_read_id_i,
    input  mem_req_read_ready_o,
    input  mem_resp_read_valid_o, mem_resp_read_data_o,
    input  mem_resp_read_id_o, mem_resp_read_error_o,
    input  mem_resp_read_last_o,
    output mem_resp_read_ready_i,
    output mem_req_write_valid_i, mem_req_write_addr_i,
    output mem_req_write_len_i, mem_req_write_id_i,
    input  mem_req_write_ready_o,
    output mem_req_write_data_valid_i, mem_req_write_data_i,
    output mem_req_write_be_i, mem_req_write_last_i,
    input  mem_req_write_data_ready_o,
    input  mem_resp_write_valid_o, mem_resp_write_id_o,
    input  mem_resp_write_error_o,
    output mem_resp_write_ready_i
  );
endinterface

// File: rtl/hpdcache_mem_responder.sv
// Register-array memory target for the HPDcache memory interface.
// Independent read and write FSMs, one burst in flight on each.
module hpdcache_mem_responder #(
  parameter int              ADDR_W     = 56,
  parameter int              ID_W       = 7,
  parameter int              DATA_W     = 512,
  parameter int              DEPTH      = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              RD_LATENCY = 2
) (
  input logic clk_i,
  input logic rst_i,
  hpdcache_mem_responder_if.slave mem
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = ADDR_W + 1;
  localparam int LAT_W = 16;
  localparam logic [IDX_W-1:0] IDX_DEPTH = IDX_W'(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  logic [DATA_W-1:0] r_mem [DEPTH];

  rd_state_e        r_rd_state, w_rd_state_nxt;
  logic [ID_W-1:0]  r_rd_id;
  logic [IDX_W-1:0] r_rd_idx;
  logic             r_rd_oob;
  logic [7:0]       r_rd_rem;
  logic [LAT_W-1:0] r_rd_wait;
  logic w_rd_req_rdy, w_rd_req_hs, w_rd_vld, w_rd_beat_hs;
  logic w_rd_inrange, w_rd_last;

  wr_state_e        r_wr_state, w_wr_state_nxt;
  logic [ID_W-1:0]  r_wr_id;
  logic [IDX_W-1:0] r_wr_idx;
  logic             r_wr_oob, r_wr_err, r_wr_over;
  logic [7:0]       r_wr_len, r_wr_cnt;
  logic w_wr_req_rdy, w_wr_req_hs, w_wr_dat_rdy, w_wr_beat_hs;
  logic w_wr_inrange, w_wr_we, w_wr_vld;

  // ---------------- read path ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_state_nxt;
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    unique case (r_rd_state)
      R_IDLE:
        if (w_rd_req_hs)
          w_rd_state_nxt = (RD_LATENCY == 1) ? R_BEAT : R_WAIT;
      R_WAIT:
        if (r_rd_wait <= LAT_W'(1)) w_rd_state_nxt = R_BEAT;
      R_BEAT:
        if (w_rd_beat_hs && w_rd_last) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_req_rdy = (r_rd_state == R_IDLE) && !rst_i;
    w_rd_req_hs  = w_rd_req_rdy && mem.mem_req_read_valid_i;
    w_rd_vld     = (r_rd_state == R_BEAT);
    w_rd_beat_hs = w_rd_vld && mem.mem_resp_read_ready_i;
    w_rd_inrange = !r_rd_oob && (r_rd_idx < IDX_DEPTH);
    w_rd_last    = (r_rd_rem == 8'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_id   <= '0;
      r_rd_idx  <= '0;
      r_rd_oob  <= 1'b0;
      r_rd_rem  <= '0;
      r_rd_wait <= '0;
    end else if (w_rd_req_hs) begin
      r_rd_id   <= mem.mem_req_read_id_i;
      r_rd_idx  <= IDX_W'((mem.mem_req_read_addr_i - BASE_ADDR) >> OFF_W);
      r_rd_oob  <= mem.mem_req_read_addr_i < BASE_ADDR;
      r_rd_rem  <= mem.mem_req_read_len_i;
      r_rd_wait <= LAT_W'(RD_LATENCY - 1);
    end else if (r_rd_state == R_WAIT) begin
      r_rd_wait <= r_rd_wait - LAT_W'(1);
    end else if (w_rd_beat_hs && !w_rd_last) begin
      r_rd_idx <= r_rd_idx + IDX_W'(1);
      r_rd_rem <= r_rd_rem - 8'd1;
    end
  end

  // Array is read combinationally, so a same-edge write is not yet visible.
  assign mem.mem_req_read_ready_o  = w_rd_req_rdy;
  assign mem.mem_resp_read_valid_o = w_rd_vld;
  assign mem.mem_resp_read_data_o  =
    (w_rd_vld && w_rd_inrange) ? r_mem[r_rd_idx[AW-1:0]] : '0;
  assign mem.mem_resp_read_id_o    = w_rd_vld ? r_rd_id : '0;
  assign mem.mem_resp_read_error_o = w_rd_vld && !w_rd_inrange;
  assign mem.mem_resp_read_last_o  = w_rd_vld && w_rd_last;

  // ---------------- write path ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_wr_state <= W_IDLE;
    else       r_wr_state <= w_wr_state_nxt;
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    unique case (r_wr_state)
      W_IDLE: if (w_wr_req_hs) w_wr_state_nxt = W_DATA;
      W_DATA:
        if (w_wr_beat_hs && mem.mem_req_write_last_i)
          w_wr_state_nxt = W_RESP;
      W_RESP:
        if (mem.mem_resp_write_ready_i) w_wr_state_nxt = W_IDLE;
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_wr_req_rdy = (r_wr_state == W_IDLE) && !rst_i;
    w_wr_req_hs  = w_wr_req_rdy && mem.mem_req_write_valid_i;
    w_wr_dat_rdy = (r_wr_state == W_DATA) && !rst_i;
    w_wr_beat_hs = w_wr_dat_rdy && mem.mem_req_write_data_valid_i;
    w_wr_inrange = !r_wr_oob && (r_wr_idx < IDX_DEPTH);
    w_wr_we      = w_wr_beat_hs && w_wr_inrange && !r_wr_over;
    w_wr_vld     = (r_wr_state == W_RESP);
  end

  // r_wr_over: len+1 beats already taken, the rest are drained unwritten.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_id   <= '0;
      r_wr_idx  <= '0;
      r_wr_oob  <= 1'b0;
      r_wr_len  <= '0;
      r_wr_cnt  <= '0;
      r_wr_err  <= 1'b0;
      r_wr_over <= 1'b0;
    end else if (w_wr_req_hs) begin
      r_wr_id   <= mem.mem_req_write_id_i;
      r_wr_idx  <= IDX_W'((mem.mem_req_write_addr_i - BASE_ADDR) >> OFF_W);
      r_wr_oob  <= mem.mem_req_write_addr_i < BASE_ADDR;
      r_wr_len  <= mem.mem_req_write_len_i;
      r_wr_cnt  <= '0;
      r_wr_err  <= 1'b0;
      r_wr_over <= 1'b0;
    end else if (w_wr_beat_hs) begin
      if (mem.mem_req_write_last_i) begin
        r_wr_err <= r_wr_err | !w_wr_inrange | r_wr_over
                  | (r_wr_cnt != r_wr_len);
      end else begin
        r_wr_err <= r_wr_err | !w_wr_inrange;
        if (r_wr_cnt == r_wr_len) begin
          r_wr_over <= 1'b1;
        end else begin
          r_wr_cnt <= r_wr_cnt + 8'd1;
          r_wr_idx <= r_wr_idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_we) begin
      for (int j = 0; j < BE_W; j++)
        if (mem.mem_req_write_be_i[j])
          r_mem[r_wr_idx[AW-1:0]][8*j +: 8] <=
            mem.mem_req_write_data_i[8*j +: 8];
    end
  end

  assign mem.mem_req_write_ready_o      = w_wr_req_rdy;
  assign mem.mem_req_write_data_ready_o = w_wr_dat_rdy;
  assign mem.mem_resp_write_valid_o     = w_wr_vld;
  assign mem.mem_resp_write_id_o        = w_wr_vld ? r_wr_id : '0;
  assign mem.mem_resp_write_error_o     = w_wr_vld && r_wr_err;
endmodule

// File: tb/tb_hpdcache_mem_responder.sv
// Directed bench for hpdcache_mem_responder.
// BASE_ADDR=0x1000, 64-byte beats, 64 entries, read latency 2.
module tb_hpdcache_mem_responder;
  localparam int ADDR_W = 56;
  localparam int ID_W   = 7;
  localparam int DATA_W = 512;
  localparam logic [ADDR_W-1:0] BASE = 56'h1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hpdcache_mem_responder_if #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W)
  ) mif ();

  hpdcache_mem_responder #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W),
    .DEPTH(64), .BASE_ADDR(BASE), .RD_LATENCY(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mem(mif)
  );

  function automatic logic [ADDR_W-1:0] addr_of(input int idx);
    return BASE + ADDR_W'(idx * 64);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_req(input logic [ADDR_W-1:0] a, input int len,
                        input int id);
    int k = 0;
    mif.mem_req_read_addr_i  = a;
    mif.mem_req_read_len_i   = 8'(len);
    mif.mem_req_read_id_i    = 7'(id);
    mif.mem_req_read_valid_i = 1'b1;
    while (!mif.mem_req_read_ready_o && k < 50) begin tick(); k++; end
    if (!mif.mem_req_read_ready_o) begin
      n_cmp++; n_err++;
      $display("FAIL rd_req_timeout: ready=0 required 1");
    end
    tick();
    mif.mem_req_read_valid_i = 1'b0;
  endtask

  task automatic wr_req(input int idx, input int len, input int id);
    int k = 0;
    mif.mem_req_write_addr_i  = addr_of(idx);
    mif.mem_req_write_len_i   = 8'(len);
    mif.mem_req_write_id_i    = 7'(id);
    mif.mem_req_write_valid_i = 1'b1;
    while (!mif.mem_req_write_ready_o && k < 50) begin tick(); k++; end
    if (!mif.mem_req_write_ready_o) begin
      n_cmp++; n_err++;
      $display("FAIL wr_req_timeout: ready=0 required 1");
    end
    tick();
    mif.mem_req_write_valid_i = 1'b0;
  endtask

  task automatic wr_beat(input logic [DATA_W-1:0] d,
                         input logic [DATA_W/8-1:0] be, input logic last);
    int k = 0;
    mif.mem_req_write_data_i       = d;
    mif.mem_req_write_be_i         = be;
    mif.mem_req_write_last_i       = last;
    mif.mem_req_write_data_valid_i = 1'b1;
    while (!mif.mem_req_write_data_ready_o && k < 50) begin tick(); k++; end
    if (!mif.mem_req_write_data_ready_o) begin
      n_cmp++; n_err++;
      $display("FAIL wr_beat_timeout: data_ready=0 required 1");
    end
    tick();
    mif.mem_req_write_data_valid_i = 1'b0;
    mif.mem_req_write_last_i       = 1'b0;
  endtask

  task automatic wr_resp(output logic [ID_W-1:0] id, output logic err);
    int k = 0;
    mif.mem_resp_write_ready_i = 1'b1;
    while (!mif.mem_resp_write_valid_o && k < 50) begin tick(); k++; end
    if (!mif.mem_resp_write_valid_o) begin
      n_cmp++; n_err++;
      $display("FAIL wr_resp_timeout: valid=0 required 1");
    end
    id  = mif.mem_resp_write_id_o;
    err = mif.mem_resp_write_error_o;
    tick();
    mif.mem_resp_write_ready_i = 1'b0;
  endtask

  task automatic rd_beat(output logic [DATA_W-1:0] d, output logic err,
                         output logic last, output int waited);
    waited = 0;
    mif.mem_resp_read_ready_i = 1'b1;
    while (!mif.mem_resp_read_valid_o && waited < 50) begin
      tick(); waited++;
    end
    if (!mif.mem_resp_read_valid_o) begin
      n_cmp++; n_err++;
      $display("FAIL rd_beat_timeout: valid=0 required 1");
    end
    d    = mif.mem_resp_read_data_o;
    err  = mif.mem_resp_read_error_o;
    last = mif.mem_resp_read_last_o;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if (mif.mem_req_read_ready_o !== 1'b0 ||
        mif.mem_req_write_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_low: rd=%b wr=%b required 0 0",
               mif.mem_req_read_ready_o, mif.mem_req_write_ready_o);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mif.mem_req_read_ready_o !== 1'b1 ||
        mif.mem_req_write_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_high: rd=%b wr=%b required 1 1",
               mif.mem_req_read_ready_o, mif.mem_req_write_ready_o);
    end
    n_cmp++;
    if ({mif.mem_resp_read_valid_o, mif.mem_resp_write_valid_o,
         mif.mem_req_write_data_ready_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_valids: rdv=%b wrv=%b dr=%b required 0",
               mif.mem_resp_read_valid_o, mif.mem_resp_write_valid_o,
               mif.mem_req_write_data_ready_o);
    end
    n_cmp++;
    if (mif.mem_resp_read_data_o !== '0 || mif.mem_resp_read_last_o !== 1'b0
        || mif.mem_resp_read_error_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rd_fields: data=%h required 0",
               mif.mem_resp_read_data_o);
    end
  endtask

  task automatic test_write_read();
    logic [ID_W-1:0] id;
    logic e;
    wr_req(1, 0, 5);
    wr_beat({64{8'hA5}}, '1, 1'b1);
    wr_resp(id, e);
    n_cmp++;
    if (id !== 7'd5 || e !== 1'b0) begin
      n_err++;
      $display("FAIL wr_resp_basic: id=%0d err=%b required 5 0", id, e);
    end
    rd_req(addr_of(1), 0, 3);
    n_cmp++;
    if (mif.mem_resp_read_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rd_latency_early: valid=1 required 0");
    end
    tick();
    n_cmp++;
    if (mif.mem_resp_read_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL rd_latency_due: valid=0 required 1");
    end
    n_cmp++;
    if (mif.mem_resp_read_data_o !== {64{8'hA5}}) begin
      n_err++;
      $display("FAIL rd_basic_data: %h required a5..",
               mif.mem_resp_read_data_o);
    end
    n_cmp++;
    if (mif.mem_resp_read_id_o !== 7'd3 || mif.mem_resp_read_last_o !== 1'b1
        || mif.mem_resp_read_error_o !== 1'b0) begin
      n_err++;
      $display("FAIL rd_basic_fields: id=%0d last=%b err=%b required 3 1 0",
               mif.mem_resp_read_id_o, mif.mem_resp_read_last_o,
               mif.mem_resp_read_error_o);
    end
    mif.mem_resp_read_ready_i = 1'b1;
    tick();
    mif.mem_resp_read_ready_i = 1'b0;
    n_cmp++;
    if (mif.mem_resp_read_valid_o !== 1'b0 ||
        mif.mem_req_read_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL rd_basic_done: valid=%b req_ready=%b required 0 1",
               mif.mem_resp_read_valid_o, mif.mem_req_read_ready_o);
    end
  endtask

  task automatic test_byte_enable();
    logic [ID_W-1:0] id;
    logic e, l;
    logic [DATA_W-1:0] d;
    int w;
    wr_req(2, 0, 1);
    wr_beat({{63{8'hFF}}, 8'h7E}, 64'h1, 1'b1);
    wr_resp(id, e);
    rd_req(addr_of(2), 0, 2);
    rd_beat(d, e, l, w);
    mif.mem_resp_read_ready_i = 1'b0;
    n_cmp++;
    if (d !== 512'h7E || e !== 1'b0 || l !== 1'b1) begin
      n_err++;
      $display("FAIL byte_enable: data=%h err=%b last=%b required 7e 0 1",
               d, e, l);
    end
  endtask

  task automatic test_oob_burst();
    logic [ID_W-1:0] id;
    logic e, l;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_d [4];
    int w;
    exp_d[0] = {64{8'h62}};
    exp_d[1] = {64{8'h63}};
    exp_d[2] = '0;
    exp_d[3] = '0;
    wr_req(62, 1, 4);
    wr_beat({64{8'h62}}, '1, 1'b0);
    wr_beat({64{8'h63}}, '1, 1'b1);
    wr_resp(id, e);
    n_cmp++;
    if (e !== 1'b0) begin
      n_err++;
      $display("FAIL wr_edge_inrange: err=%b required 0", e);
    end
    wr_req(63, 1, 4);
    wr_beat({64{8'h63}}, '1, 1'b0);
    wr_beat({64{8'hEE}}, '1, 1'b1);
    wr_resp(id, e);
    n_cmp++;
    if (e !== 1'b1) begin
      n_err++;
      $display("FAIL wr_past_end: err=%b required 1", e);
    end
    rd_req(addr_of(62), 3, 9);
    for (int b = 0; b < 4; b++) begin
      rd_beat(d, e, l, w);
      n_cmp++;
      if (d !== exp_d[b] || e !== (b >= 2) || l !== (b == 3)) begin
        n_err++;
        $display("FAIL oob_beat%0d: data=%h err=%b last=%b required %h %b %b",
                 b, d, e, l, exp_d[b], (b >= 2), (b == 3));
      end
      if (b > 0) begin
        n_cmp++;
        if (w !== 0) begin
          n_err++;
          $display("FAIL oob_bubble%0d: waited=%0d required 0", b, w);
        end
      end
    end
    mif.mem_resp_read_ready_i = 1'b0;
    rd_req(56'h0, 0, 1);
    rd_beat(d, e, l, w);
    mif.mem_resp_read_ready_i = 1'b0;
    n_cmp++;
    if (e !== 1'b1 || d !== '0) begin
      n_err++;
      $display("FAIL below_base: err=%b data=%h required 1 0", e, d);
    end
  endtask

  task automatic test_stall();
    rd_req(addr_of(1), 3, 6);
    n_cmp++;
    if (mif.mem_req_read_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_req_busy: req_ready=1 required 0");
    end
    tick();
    mif.mem_resp_read_ready_i = 1'b1;
    n_cmp++;
    if (mif.mem_resp_read_valid_o !== 1'b1 ||
        mif.mem_resp_read_data_o !== {64{8'hA5}}) begin
      n_err++;
      $display("FAIL stall_beat0: valid=%b data=%h required 1 a5..",
               mif.mem_resp_read_valid_o, mif.mem_resp_read_data_o);
    end
    tick();
    mif.mem_resp_read_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) mif.mem_resp_read_ready_i = 1'b1;
      n_cmp++;
      if (mif.mem_resp_read_valid_o !== 1'b1 ||
          mif.mem_resp_read_data_o !== 512'h7E ||
          mif.mem_resp_read_last_o !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: valid=%b last=%b data=%h required 1 0 7e",
                 c, mif.mem_resp_read_valid_o, mif.mem_resp_read_last_o,
                 mif.mem_resp_read_data_o);
      end
      tick();
    end
    n_cmp++;
    if (mif.mem_resp_read_data_o !== '0 || mif.mem_resp_read_last_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_beat2: data=%h last=%b required 0 0",
               mif.mem_resp_read_data_o, mif.mem_resp_read_last_o);
    end
    tick();
    n_cmp++;
    if (mif.mem_resp_read_last_o !== 1'b1 ||
        mif.mem_req_read_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_beat3: last=%b req_ready=%b required 1 0",
               mif.mem_resp_read_last_o, mif.mem_req_read_ready_o);
    end
    tick();
    mif.mem_resp_read_ready_i = 1'b0;
    n_cmp++;
    if (mif.mem_resp_read_valid_o !== 1'b0 ||
        mif.mem_req_read_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done: valid=%b req_ready=%b required 0 1",
               mif.mem_resp_read_valid_o, mif.mem_req_read_ready_o);
    end
  endtask

  task automatic test_len_mismatch();
    logic [ID_W-1:0] id;
    logic e, l;
    logic [DATA_W-1:0] d0, d1;
    int w;
    mif.mem_req_write_data_valid_i = 1'b1;
    #1;
    n_cmp++;
    if (mif.mem_req_write_data_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL early_data: data_ready=1 required 0");
    end
    mif.mem_req_write_data_valid_i = 1'b0;
    wr_req(5, 1, 7);
    wr_beat({64{8'h11}}, '1, 1'b1);
    wr_resp(id, e);
    n_cmp++;
    if (id !== 7'd7 || e !== 1'b1) begin
      n_err++;
      $display("FAIL short_burst: id=%0d err=%b required 7 1", id, e);
    end
    wr_req(6, 0, 8);
    wr_beat({64{8'h22}}, '1, 1'b1);
    wr_resp(id, e);
    n_cmp++;
    if (id !== 7'd8 || e !== 1'b0) begin
      n_err++;
      $display("FAIL after_short: id=%0d err=%b required 8 0", id, e);
    end
    wr_req(8, 0, 10);
    wr_beat({64{8'h33}}, '1, 1'b0);
    wr_beat({64{8'h44}}, '1, 1'b1);
    wr_resp(id, e);
    n_cmp++;
    if (e !== 1'b1) begin
      n_err++;
      $display("FAIL long_burst: err=%b required 1", e);
    end
    rd_req(addr_of(8), 1, 2);
    rd_beat(d0, e, l, w);
    rd_beat(d1, e, l, w);
    mif.mem_resp_read_ready_i = 1'b0;
    n_cmp++;
    if (d0 !== {64{8'h33}} || d1 !== '0) begin
      n_err++;
      $display("FAIL long_burst_mem: d0=%h d1=%h required 33.. 0", d0, d1);
    end
    rd_req(addr_of(5), 1, 2);
    rd_beat(d0, e, l, w);
    rd_beat(d1, e, l, w);
    mif.mem_resp_read_ready_i = 1'b0;
    n_cmp++;
    if (d0 !== {64{8'h11}} || d1 !== {64{8'h22}}) begin
      n_err++;
      $display("FAIL short_burst_mem: d0=%h d1=%h required 11.. 22..", d0, d1);
    end
  endtask

  task automatic test_reset_mid();
    logic e, l;
    logic [DATA_W-1:0] d;
    int w;
    wr_req(10, 3, 12);
    wr_beat({64{8'h55}}, '1, 1'b0);
    rd_req(addr_of(1), 3, 13);
    tick();
    mif.mem_resp_read_ready_i = 1'b1;
    tick();
    mif.mem_resp_read_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mif.mem_req_read_ready_o !== 1'b0 ||
        mif.mem_req_write_ready_o !== 1'b0 ||
        mif.mem_req_write_data_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_readies: rd=%b wr=%b dr=%b required 0",
               mif.mem_req_read_ready_o, mif.mem_req_write_ready_o,
               mif.mem_req_write_data_ready_o);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mif.mem_resp_read_valid_o !== 1'b0 ||
        mif.mem_resp_write_valid_o !== 1'b0 ||
        mif.mem_req_read_ready_o !== 1'b1 ||
        mif.mem_req_write_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rst_state: rdv=%b wrv=%b rdr=%b wrr=%b required 0 0 1 1",
               mif.mem_resp_read_valid_o, mif.mem_resp_write_valid_o,
               mif.mem_req_read_ready_o, mif.mem_req_write_ready_o);
    end
    rd_req(addr_of(1), 0, 1);
    rd_beat(d, e, l, w);
    mif.mem_resp_read_ready_i = 1'b0;
    n_cmp++;
    if (d !== '0) begin
      n_err++;
      $display("FAIL mid_rst_zero1: data=%h required 0", d);
    end
    rd_req(addr_of(10), 0, 1);
    rd_beat(d, e, l, w);
    mif.mem_resp_read_ready_i = 1'b0;
    n_cmp++;
    if (d !== '0 || mif.mem_resp_write_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_zero10: data=%h wrv=%b required 0 0",
               d, mif.mem_resp_write_valid_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mif.mem_req_read_valid_i       = 1'b0;
    mif.mem_req_read_addr_i        = '0;
    mif.mem_req_read_len_i         = '0;
    mif.mem_req_read_id_i          = '0;
    mif.mem_resp_read_ready_i      = 1'b0;
    mif.mem_req_write_valid_i      = 1'b0;
    mif.mem_req_write_addr_i       = '0;
    mif.mem_req_write_len_i        = '0;
    mif.mem_req_write_id_i         = '0;
    mif.mem_req_write_data_valid_i = 1'b0;
    mif.mem_req_write_data_i       = '0;
    mif.mem_req_write_be_i         = '0;
    mif.mem_req_write_last_i       = 1'b0;
    mif.mem_resp_write_ready_i     = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_oob_burst();
    test_stall();
    test_len_mismatch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hpdcache_mem_responder.md
Name: hpdcache_mem_responder

Overview:
Synthesizable memory-side responder for the HPDcache memory interface: the target end of the read-request/read-response and write-request/write-data/write-response channels the cache drives as initiator. Backs requests with an internal register array of DEPTH beats, with configurable read latency. Used in synthesis/FPGA test harnesses and as the reference slave in cache benches. Read and write paths are independent FSMs, each handling one transaction at a time.

Parameters:
ADDR_W, 56, memory address width (matches memAddrWidth)
ID_W, 7, transaction ID width (matches memIdWidth)
DATA_W, 512, beat width in bits (matches memDataWidth); power of two >= 64
DEPTH, 64, number of DATA_W-bit beats in the array; power of two
BASE_ADDR, 0, byte address of array index 0; DATA_W/8 aligned
RD_LATENCY, 2, cycles from read-request acceptance to first read-response valid; >= 1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
mem_req_read_valid_i  in  1  read request valid
mem_req_read_ready_o  out  1  read request ready
mem_req_read_addr_i  in  ADDR_W  byte address of first beat
mem_req_read_len_i  in  8  beats minus one
mem_req_read_id_i  in  ID_W  transaction ID
mem_resp_read_valid_o  out  1  read beat valid
mem_resp_read_ready_i  in  1  read beat ready
mem_resp_read_data_o  out  DATA_W  beat data
mem_resp_read_id_o  out  ID_W  echoed ID
mem_resp_read_error_o  out  1  beat out of range
mem_resp_read_last_o  out  1  final beat
mem_req_write_valid_i  in  1  write request valid
mem_req_write_ready_o  out  1  write request ready
mem_req_write_addr_i  in  ADDR_W  byte address of first beat
mem_req_write_len_i  in  8  beats minus one
mem_req_write_id_i  in  ID_W  transaction ID
mem_req_write_data_valid_i  in  1  write beat valid
mem_req_write_data_ready_o  out  1  write beat ready
mem_req_write_data_i  in  DATA_W  write beat data
mem_req_write_be_i  in  DATA_W/8  byte enables
mem_req_write_last_i  in  1  final write beat
mem_resp_write_valid_o  out  1  write response valid
mem_resp_write_ready_i  in  1  write response ready
mem_resp_write_id_o  out  ID_W  echoed ID
mem_resp_write_error_o  out  1  error (range or beat-count mismatch)

Behaviour:
- Transfer on valid&&ready at rising edge. Outputs, once valid, are held stable until accepted.
- Address map: idx = (addr - BASE_ADDR) >> log2(DATA_W/8); addr low bits are ignored. A beat is in range iff addr >= BASE_ADDR and idx < DEPTH. Beat k uses idx+k with no wrap; beats past DEPTH-1 are errors.
- Reset (rst_i=1 at edge): both FSMs go idle, array is zeroed, all valid outputs are 0, data/id/error/last are 0, and all ready outputs are 0 while rst_i is high.
- In-flight bursts are dropped with no further beats or responses.
- First cycle after reset: request readies are 1.
- Read FSM states:
  - R_IDLE: req_read_ready=1. On accept, latch id/idx/len; load wait counter with RD_LATENCY-1; go to R_WAIT, or R_BEAT if RD_LATENCY=1.
  - R_WAIT: count down; at 0 go to R_BEAT. First beat is valid exactly RD_LATENCY cycles after the accept edge.
  - R_BEAT: valid=1; data = array[idx] combinationally, or 0 with error=1 if out of range; last=(remaining==0).
    - On accept with last: go to R_IDLE; req_read_ready rises the next cycle.
    - Otherwise: idx+1, remaining-1. No bubble between beats under continuous ready.
- Write FSM states:
  - W_IDLE: req_write_ready=1. On accept, latch id/idx/len; clear beat counter and error; go to W_DATA.
  - W_DATA: data_ready=1. Each accepted beat writes byte j of array[idx] iff be[j], only when in range; an out-of-range beat sets the sticky error.
    - On the beat with last=1: error |= (count != len). Go to W_RESP.
    - If count == len is reached without last: keep accepting until last, flag error, and stop writing the array after len+1 beats.
  - W_RESP: resp valid=1 with id/error; on accept go to W_IDLE.
- Write data presented before the request is accepted is not consumed (data_ready=0 outside W_DATA).
- Same-cycle read and write to one index: the read beat returns pre-write data; the write is visible from the next cycle.
- len is 8 bits: bursts are up to 256 beats; counters are 8 bits and do not wrap.

Test Plan:
- Write addr=BASE_ADDR+0x40 (idx 1), len=0, data=0xA5.., be all-ones, id=5 -> resp id=5 error=0. Then read same, len=0, id=3 -> one beat 0xA5.., last=1, error=0, valid exactly RD_LATENCY=2 cycles after accept.
- Write idx 2 with be=0x...01 and data byte0=0x7E over zeroed memory; read back -> byte0=0x7E, other bytes 0.
- Read idx 62, len=3, continuous ready -> 4 consecutive beats; beats 0-1 error=0, beats 2-3 error=1 data=0; last only on beat 3.
- Read len=3 with mem_resp_read_ready toggling 1,0,0,1 -> valid/data/last stable while stalled; total 4 beats; req_read_ready=0 until the cycle after last accepted.
- Write len=1 but last asserted on first beat -> resp error=1; only that beat written; next write accepted normally.
- Assert rst_i mid read burst (after beat 1 of 4) and mid W_DATA -> next cycle all valids 0, readies 1, array zeroed, no stale response.
